// File: rtl/datamem_ls.sv
// datamem_ls: byte-addressable RV32 data memory with byte-lane stores,
// sign/zero-extending loads, a registered read port and a request handshake.
// Optional feature macro: DATAMEM_MISALIGN_EN. When defined, misaligned
// accesses are split into two beats (word W, then word (W+1) mod DEPTH).
// When undefined, misaligned requests still pulse misalign, stores write
// nothing and loads return 0.
module datamem_ls #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int MEM_BYTES_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  MemWrite,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  rdata_valid,
  output logic                  stall,
  output logic                  misalign,
  output logic                  dbg_state
);

  localparam int IW    = MEM_BYTES_LOG2 - 2;
  localparam int DEPTH = 1 << IW;

  // Handshake: a request is taken on a rising edge where req_valid and
  // req_ready are both 1; while req_ready is 0 the requester holds its
  // request and req_valid is ignored. req_ready is 1 exactly in IDLE.
  typedef enum logic {IDLE, SECOND} state_t;
  state_t state, state_nx;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    accept;
  logic [IW-1:0]           widx;
  logic [IW-1:0]           widx_nx;
  logic [1:0]              off;
  logic [3:0]              bmask;
  logic [7:0]              mask8;
  logic [2*DATA_WIDTH-1:0] wdata64;
  logic                    is_mis;

  // Second-beat context captured when a request is accepted
  logic [IW-1:0]           sec_idx;
  logic [3:0]              sec_mask;
  logic [DATA_WIDTH-1:0]   sec_data;
  logic                    sec_store;
  logic [1:0]              sec_off;
  logic [2:0]              sec_f3;
  logic [DATA_WIDTH-1:0]   hold;

  // Memory write port
  logic                    wr_en;
  logic [IW-1:0]           wr_idx;
  logic [3:0]              wr_lanes;
  logic [DATA_WIDTH-1:0]   wr_data;

  logic                    unused_addr;
  assign unused_addr = ^addr[ADDR_WIDTH-1:MEM_BYTES_LOG2];

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign widx      = addr[MEM_BYTES_LOG2-1:2];
  assign widx_nx   = widx + 1'b1;
  assign off       = addr[1:0];
  assign dbg_state = (state == SECOND);

  // Spread the access size over an 8-lane window: lanes 0-3 fall in word W,
  // lanes 4-7 spill into word W+1 (the spill is what makes it misaligned).
  assign mask8   = {4'b0000, bmask} << off;
  assign wdata64 = {{DATA_WIDTH{1'b0}}, WriteData} << {off, 3'b000};
  assign is_mis  = |mask8[7:4];
  assign misalign = accept && is_mis;

`ifdef DATAMEM_MISALIGN_EN
  assign stall = (state == SECOND);
`else
  assign stall = 1'b0;
`endif

  // Decode funct3 into a base byte mask; unsupported codes give an empty mask
  always_comb begin
    bmask = 4'b0000;
    if (MemWrite) begin
      case (funct3)
        3'b000:  bmask = 4'b0001;
        3'b001:  bmask = 4'b0011;
        3'b010:  bmask = 4'b1111;
        default: bmask = 4'b0000;
      endcase
    end else begin
      case (funct3)
        3'b000, 3'b100: bmask = 4'b0001;
        3'b001, 3'b101: bmask = 4'b0011;
        3'b010:         bmask = 4'b1111;
        default:        bmask = 4'b0000;
      endcase
    end
  end

  // Shift the addressed bytes down to lane 0 and extend per funct3
  function automatic logic [DATA_WIDTH-1:0] extend(input logic [2*DATA_WIDTH-1:0] pair,
                                                   input logic [1:0] o,
                                                   input logic [2:0] f3);
    logic [DATA_WIDTH-1:0] sh;
    sh = DATA_WIDTH'(pair >> {o, 3'b000});
    case (f3)
      3'b000:  extend = {{24{sh[7]}}, sh[7:0]};
      3'b001:  extend = {{16{sh[15]}}, sh[15:0]};
      3'b010:  extend = sh;
      3'b100:  extend = {24'b0, sh[7:0]};
      3'b101:  extend = {16'b0, sh[15:0]};
      default: extend = '0;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state: SECOND lasts exactly one cycle
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
`ifdef DATAMEM_MISALIGN_EN
        if (accept && is_mis) state_nx = SECOND;
`endif
      end
      SECOND:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Select the write for this cycle: first beat on accept, rest in SECOND
  always_comb begin
    wr_en    = 1'b0;
    wr_idx   = widx;
    wr_lanes = mask8[3:0];
    wr_data  = wdata64[DATA_WIDTH-1:0];
    if (state == SECOND) begin
      wr_en    = sec_store;
      wr_idx   = sec_idx;
      wr_lanes = sec_mask;
      wr_data  = sec_data;
    end else if (accept && MemWrite) begin
`ifdef DATAMEM_MISALIGN_EN
      wr_en = 1'b1;
`else
      wr_en = !is_mis;
`endif
    end
  end

  // Byte-lane writes into the (unreset) array; nothing commits under reset
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_lanes[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Registered read port, hold register and second-beat context
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ReadData    <= '0;
      rdata_valid <= 1'b0;
      hold        <= '0;
      sec_idx     <= '0;
      sec_mask    <= 4'b0000;
      sec_data    <= '0;
      sec_store   <= 1'b0;
      sec_off     <= 2'b00;
      sec_f3      <= 3'b000;
    end else begin
      rdata_valid <= 1'b0;
      if (accept) begin
        sec_idx   <= widx_nx;
        sec_mask  <= mask8[7:4];
        sec_data  <= wdata64[2*DATA_WIDTH-1:DATA_WIDTH];
        sec_store <= MemWrite;
        sec_off   <= off;
        sec_f3    <= funct3;
        if (!MemWrite) begin
          if (is_mis) begin
`ifdef DATAMEM_MISALIGN_EN
            hold <= mem[widx];
`else
            ReadData    <= '0;
            rdata_valid <= 1'b1;
`endif
          end else begin
            ReadData    <= extend({{DATA_WIDTH{1'b0}}, mem[widx]}, off, funct3);
            rdata_valid <= 1'b1;
          end
        end
      end
      if (state == SECOND && !sec_store) begin
        ReadData    <= extend({mem[sec_idx], hold}, sec_off, sec_f3);
        rdata_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_datamem_ls.sv
// tb_datamem_ls: table-driven and model-driven checks for datamem_ls,
// with a scoreboard queue of expected load results and their due cycles.
module tb_datamem_ls;

`ifdef DATAMEM_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] WriteData = '0;
  logic        req_ready;
  logic [31:0] ReadData;
  logic        rdata_valid;
  logic        stall;
  logic        misalign;
  logic        dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] exp_q[$];
  int          due_q[$];
  logic [7:0]  model [4096];

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp;
    logic        mis;
  } vec_t;
  vec_t vecs[$];

  datamem_ls dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .MemWrite(MemWrite), .funct3(funct3), .addr(addr), .WriteData(WriteData),
    .ReadData(ReadData), .rdata_valid(rdata_valid), .stall(stall),
    .misalign(misalign), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic we, input logic [2:0] f3);
    if (we) begin
      case (f3)
        3'b000:  return 1;
        3'b001:  return 2;
        3'b010:  return 4;
        default: return 0;
      endcase
    end
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic logic mis_of(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int n;
    n = acc_size(we, f3);
    return (n > 0) && ((int'(a[1:0]) + n) > 4);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    logic [31:0] ba;
    int n;
    v = '0;
    n = acc_size(1'b0, f3);
    if (n == 0) return '0;
    if (mis_of(1'b0, f3, a) && !MIS_EN) return '0;
    for (int i = 0; i < n; i++) begin
      ba = a + 32'(i);
      v[8*i +: 8] = model[ba[11:0]];
    end
    if (f3 == 3'b000) v = {{24{v[7]}}, v[7:0]};
    if (f3 == 3'b001) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] ba;
    int n;
    n = acc_size(1'b1, f3);
    if (mis_of(1'b1, f3, a) && !MIS_EN) n = 0;
    for (int i = 0; i < n; i++) begin
      ba = a + 32'(i);
      model[ba[11:0]] = wd[8*i +: 8];
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp, input logic exp_mis);
    int waits;
    waits = 0;
    @(negedge clk);
    req_valid = 1'b1;
    MemWrite  = we;
    funct3    = f3;
    addr      = a;
    WriteData = wd;
    #1;
    while (!req_ready && waits < 5) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL req_ready_timeout: got 0 want 1 at addr %h", a);
    end
    check("misalign", 32'(misalign), 32'(exp_mis));
    if (!we) begin
      exp_q.push_back(exp);
      due_q.push_back(cyc + ((exp_mis && MIS_EN) ? 2 : 1));
    end else begin
      model_store(f3, a, wd);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
    MemWrite  = 1'b0;
  endtask

  task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] exp, input logic mis);
    vec_t v;
    v.we = we; v.f3 = f3; v.a = a; v.wd = wd; v.exp = exp; v.mis = mis;
    vecs.push_back(v);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (rdata_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_rdata_valid: got data %h want no result", ReadData);
        end else begin
          check("load_data", ReadData, exp_q.pop_front());
          check("load_cycle", 32'(cyc), 32'(due_q.pop_front()));
        end
      end
      if (due_q.size() > 0 && cyc > due_q[0]) begin
        total++;
        bad++;
        $display("FAIL missing_rdata_valid: got none want %h by cycle %0d", exp_q[0], due_q[0]);
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
`ifndef DATAMEM_MISALIGN_EN
      check("stall_tied_low", 32'(stall), 32'd0);
`endif
    end
  end

  // ---------------- test ----------------
  initial begin
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_a;
    logic [31:0] r_wd;
    logic [31:0] r_exp;
    int          tmp;
    int          guard;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_rdata_valid", 32'(rdata_valid), 32'd0);
    check("rst_readdata", ReadData, 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;

    // Vector table, applied back to back
    add(1, 3'b010, 32'h10, 32'h80FF7F01, 32'h0, 0);
    add(0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 0);
    add(0, 3'b100, 32'h13, 32'h0, 32'h00000080, 0);
    add(0, 3'b001, 32'h10, 32'h0, 32'h00007F01, 0);
    add(0, 3'b101, 32'h10, 32'h0, 32'h00007F01, 0);
    add(0, 3'b001, 32'h12, 32'h0, 32'hFFFF80FF, 0);
    add(0, 3'b101, 32'h12, 32'h0, 32'h000080FF, 0);
    add(0, 3'b000, 32'h11, 32'h0, 32'h0000007F, 0);
    add(0, 3'b000, 32'h12, 32'h0, 32'hFFFFFFFF, 0);
    add(0, 3'b010, 32'h10, 32'h0, 32'h80FF7F01, 0);
    add(1, 3'b010, 32'h20, 32'h11223344, 32'h0, 0);
    add(1, 3'b000, 32'h21, 32'h123456AA, 32'h0, 0);
    add(0, 3'b010, 32'h20, 32'h0, 32'h1122AA44, 0);
    add(1, 3'b001, 32'h22, 32'h9999BEEF, 32'h0, 0);
    add(0, 3'b010, 32'h20, 32'h0, 32'hBEEFAA44, 0);
    add(0, 3'b001, 32'h22, 32'h0, 32'hFFFFBEEF, 0);
    add(0, 3'b011, 32'h20, 32'h0, 32'h0, 0);
    add(0, 3'b110, 32'h20, 32'h0, 32'h0, 0);
    add(0, 3'b111, 32'h20, 32'h0, 32'h0, 0);
    add(1, 3'b011, 32'h20, 32'hFFFFFFFF, 32'h0, 0);
    add(1, 3'b100, 32'h20, 32'hFFFFFFFF, 32'h0, 0);
    add(0, 3'b010, 32'h20, 32'h0, 32'hBEEFAA44, 0);
    add(1, 3'b000, 32'hFFF, 32'h12, 32'h0, 0);
    add(1, 3'b000, 32'h000, 32'h34, 32'h0, 0);
    add(1, 3'b001, 32'hFFF, 32'hBEEF, 32'h0, 1);
    add(0, 3'b100, 32'hFFF, 32'h0, MIS_EN ? 32'hEF : 32'h12, 0);
    add(0, 3'b100, 32'h000, 32'h0, MIS_EN ? 32'hBE : 32'h34, 0);
    add(0, 3'b001, 32'hFFF, 32'h0, MIS_EN ? 32'hFFFFBEEF : 32'h0, 1);
`ifndef DATAMEM_MISALIGN_EN
    add(0, 3'b010, 32'h11, 32'h0, 32'h0, 1);
    add(0, 3'b001, 32'h13, 32'h0, 32'h0, 1);
    add(0, 3'b010, 32'h01, 32'h0, 32'h0, 1);
    add(1, 3'b010, 32'h12, 32'hFFFFFFFF, 32'h0, 1);
    add(1, 3'b001, 32'h13, 32'hFFFFFFFF, 32'h0, 1);
    add(0, 3'b010, 32'h10, 32'h0, 32'h80FF7F01, 0);
    add(0, 3'b010, 32'h20, 32'h0, 32'hBEEFAA44, 0);
`endif
    for (int i = 0; i < vecs.size(); i++)
      do_req(vecs[i].we, vecs[i].f3, vecs[i].a, vecs[i].wd, vecs[i].exp, vecs[i].mis);
    idle();

    // ReadData holds after its one-cycle valid pulse
    do_req(0, 3'b010, 32'h10, 32'h0, 32'h80FF7F01, 0);
    idle();
    repeat (3) @(negedge clk);
    check("readdata_hold", ReadData, 32'h80FF7F01);
    check("valid_one_cycle", 32'(rdata_valid), 32'd0);

    // Async reset right after a load is accepted: result is dropped
    @(negedge clk);
    req_valid = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; addr = 32'h20;
    @(posedge clk);
    #2;
    rst = 1'b1;
    req_valid = 1'b0;
    exp_q.delete();
    due_q.delete();
    #1;
    check("midrst_rdata_valid", 32'(rdata_valid), 32'd0);
    check("midrst_readdata", ReadData, 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    do_req(0, 3'b010, 32'h20, 32'h0, 32'hBEEFAA44, 0);

`ifdef DATAMEM_MISALIGN_EN
    // Misaligned word store: one stall cycle, then readable at T+2
    do_req(1, 3'b010, 32'h0E, 32'hDEADBEEF, 32'h0, 1);
    @(negedge clk);
    req_valid = 1'b0;
    check("split_stall", 32'(stall), 32'd1);
    check("split_not_ready", 32'(req_ready), 32'd0);
    check("split_state", 32'(dbg_state), 32'd1);
    @(negedge clk);
    check("split_stall_done", 32'(stall), 32'd0);
    check("split_ready_again", 32'(req_ready), 32'd1);
    do_req(0, 3'b010, 32'h0E, 32'h0, 32'hDEADBEEF, 1);
    do_req(0, 3'b100, 32'h0E, 32'h0, 32'hEF, 0);
    do_req(0, 3'b100, 32'h0F, 32'h0, 32'hBE, 0);
    do_req(0, 3'b100, 32'h10, 32'h0, 32'hAD, 0);
    do_req(0, 3'b100, 32'h11, 32'h0, 32'hDE, 0);
    do_req(0, 3'b101, 32'h0F, 32'h0, 32'hADBE, 1);

    // Reset during the second beat of a misaligned store
    do_req(1, 3'b010, 32'h1C, 32'h0, 32'h0, 0);
    do_req(1, 3'b010, 32'h20, 32'h55667788, 32'h0, 0);
    do_req(1, 3'b010, 32'h1E, 32'hA1B2C3D4, 32'h0, 1);
    #2;
    rst = 1'b1;
    req_valid = 1'b0;
    #1;
    check("sec_rst_state", 32'(dbg_state), 32'd0);
    check("sec_rst_stall", 32'(stall), 32'd0);
    check("sec_rst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    do_req(0, 3'b010, 32'h1C, 32'h0, 32'hC3D40000, 0);
    do_req(0, 3'b010, 32'h20, 32'h0, 32'h55667788, 0);
`endif

    // Random traffic in a pre-initialised region against the byte model
    for (int i = 0; i < 16; i++)
      do_req(1, 3'b010, 32'h100 + 32'(4 * i), $urandom, 32'h0, 0);
    for (int i = 0; i < 80; i++) begin
      r_we = 1'($urandom_range(0, 1));
      if (r_we) begin
        r_f3 = 3'($urandom_range(0, 2));
      end else begin
        tmp  = $urandom_range(0, 4);
        r_f3 = (tmp < 3) ? 3'(tmp) : 3'(tmp + 1);
      end
      r_a   = 32'h100 + 32'($urandom_range(0, 59));
      r_wd  = $urandom;
      r_exp = model_load(r_f3, r_a);
      do_req(r_we, r_f3, r_a, r_wd, r_exp, mis_of(r_we, r_f3, r_a));
    end
    idle();

    // Drain outstanding results within a bounded number of cycles
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending results want 0", exp_q.size());
    end
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
